// File: rtl/qmult_sched_if.sv
// Bus interfaces for qmult_sched.
//   qmult_req_if : requester side. master = MAC front-ends, slave = scheduler.
//     req_vld/req_a/req_b : operands offered by each requester (lane i at [i*N +: N])
//     req_rdy             : one-hot accept from the scheduler
//     resp_vld/resp_data/resp_id : one-cycle result pulse routed to the winner
//   qmult_mul_if : multiplier side. master = scheduler, slave = shared multiplier.
//     mul_in_vld/mul_a/mul_b : start strobe and operands
//     mul_end                : multiplier idle level (high = can start)
//     mul_dout/mul_dout_vld  : product and its one-cycle valid pulse
interface qmult_req_if #(
  parameter int unsigned N       = 8,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_vld;
  logic [NUM_REQ*N-1:0] req_a;
  logic [NUM_REQ*N-1:0] req_b;
  logic [NUM_REQ-1:0]   req_rdy;
  logic [NUM_REQ-1:0]   resp_vld;
  logic [2*N-1:0]       resp_data;
  logic [ID_W-1:0]      resp_id;

  modport master (output req_vld, req_a, req_b,
                  input  req_rdy, resp_vld, resp_data, resp_id);
  modport slave  (input  req_vld, req_a, req_b,
                  output req_rdy, resp_vld, resp_data, resp_id);
endinterface

interface qmult_mul_if #(
  parameter int unsigned N = 8
);
  logic           mul_in_vld;
  logic [N-1:0]   mul_a;
  logic [N-1:0]   mul_b;
  logic           mul_end;
  logic [2*N-1:0] mul_dout;
  logic           mul_dout_vld;

  modport master (output mul_in_vld, mul_a, mul_b,
                  input  mul_end, mul_dout, mul_dout_vld);
  modport slave  (input  mul_in_vld, mul_a, mul_b,
                  output mul_end, mul_dout, mul_dout_vld);
endinterface

// File: rtl/qmult_sched.sv
// qmult_sched: shares one multi-cycle signed multiplier among NUM_REQ requesters.
// Round-robin arbitration, operand latching, start issue, result capture and
// routing of the product back to the granted requester.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   rq         : requester bus (qmult_req_if.slave)
//   mul        : shared multiplier bus (qmult_mul_if.master)
//   busy       : high whenever the scheduler is not idle
//   tmo_err    : sticky watchdog flag
// Build option: define QMULT_SCHED_TMO_EN to enable the WAIT watchdog; without
// it the scheduler waits for the multiplier indefinitely and tmo_err is 0.
module qmult_sched #(
  parameter int unsigned N       = 8,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TMO_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  qmult_req_if.slave  rq,
  qmult_mul_if.master mul,
  output logic        busy,
  output logic        tmo_err
);

  // Elaboration-time parameter sanity check
  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ || TMO_CYC <= N + 2) begin : g_cfg_chk
    $error("qmult_sched: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [ID_W-1:0]      r_last_gnt;
  logic [ID_W-1:0]      r_id;
  logic [N-1:0]         r_a;
  logic [N-1:0]         r_b;
  logic [NUM_REQ-1:0]   r_resp_vld;
  logic [2*N-1:0]       r_resp_data;
  logic [ID_W-1:0]      r_resp_id;

  logic                 w_gnt_vld;
  logic [ID_W-1:0]      w_gnt_id;
  logic [NUM_REQ-1:0]   w_gnt_oh;
  logic [N-1:0]         w_sel_a;
  logic [N-1:0]         w_sel_b;
  int unsigned          w_idx;

  // Round-robin search starting just after the last grant, wrapping to 0
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_idx     = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = (32'(r_last_gnt) + k) % NUM_REQ;
      if (!w_gnt_vld && (|(rq.req_vld & (NUM_REQ'(1) << w_idx)))) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = ID_W'(w_idx);
      end
    end
  end

  assign w_gnt_oh = NUM_REQ'(1) << w_gnt_id;
  assign w_sel_a  = N'(rq.req_a >> (32'(w_gnt_id) * N));
  assign w_sel_b  = N'(rq.req_b >> (32'(w_gnt_id) * N));

  // Accept is combinational so a requester can transfer in the same cycle it asserts valid
  assign rq.req_rdy   = (r_state == S_IDLE && w_gnt_vld) ? w_gnt_oh : '0;
  assign rq.resp_vld  = r_resp_vld;
  assign rq.resp_data = r_resp_data;
  assign rq.resp_id   = r_resp_id;

  // Start strobe follows the multiplier's idle level so a busy multiplier stalls ISSUE
  assign mul.mul_in_vld = (r_state == S_ISSUE) && mul.mul_end;
  assign mul.mul_a      = r_a;
  assign mul.mul_b      = r_b;

  assign busy = (r_state != S_IDLE);

`ifdef QMULT_SCHED_TMO_EN
  localparam int unsigned TMO_W = $clog2(TMO_CYC);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_tmo_err;

  assign tmo_err = r_tmo_err;
`else
  assign tmo_err = 1'b0;
`endif

  // Scheduler FSM with operand, result and watchdog registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last_gnt  <= ID_W'(NUM_REQ - 1);
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_resp_vld  <= '0;
      r_resp_data <= '0;
      r_resp_id   <= '0;
`ifdef QMULT_SCHED_TMO_EN
      r_tmo_cnt   <= '0;
      r_tmo_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_a        <= w_sel_a;
            r_b        <= w_sel_b;
            r_id       <= w_gnt_id;
            r_last_gnt <= w_gnt_id;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mul.mul_end) begin
            r_state   <= S_WAIT;
`ifdef QMULT_SCHED_TMO_EN
            r_tmo_cnt <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (mul.mul_dout_vld) begin
            r_resp_data <= mul.mul_dout;
            r_resp_id   <= r_id;
            r_resp_vld  <= NUM_REQ'(1) << r_id;
            r_state     <= S_RESP;
          end
`ifdef QMULT_SCHED_TMO_EN
          // Give up after TMO_CYC cycles and release the requester with a zero result
          else if (r_tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
            r_tmo_err   <= 1'b1;
            r_resp_data <= '0;
            r_resp_id   <= r_id;
            r_resp_vld  <= NUM_REQ'(1) << r_id;
            r_state     <= S_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
`endif
        end
        S_RESP: begin
          r_resp_vld <= '0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qmult_sched.sv
// Testbench for qmult_sched: directed table vectors plus hand-written
// sequences for arbitration order, reset in WAIT, ISSUE stall and watchdog.
module tb_qmult_sched;
  localparam int unsigned N   = 8;
  localparam int unsigned NR  = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic tmo_err;

  always #5 clk = ~clk;

  qmult_req_if #(.N(N), .NUM_REQ(NR), .ID_W(IDW)) rif ();
  qmult_mul_if #(.N(N)) mif ();

  qmult_sched #(.N(N), .NUM_REQ(NR), .ID_W(IDW), .TMO_CYC(TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rq      (rif),
    .mul     (mif),
    .busy    (busy),
    .tmo_err (tmo_err)
  );

  // Behavioural multi-cycle multiplier with knobs for stalls, silence and stray pulses
  logic        mdl_busy  = 1'b0;
  logic        mdl_vld   = 1'b0;
  logic [15:0] mdl_p     = '0;
  int          mdl_cnt   = 0;
  int          mul_lat   = 3;
  logic        mute      = 1'b0;
  logic        end_low   = 1'b0;
  logic        spur      = 1'b0;
  logic [15:0] spur_data = '0;

  assign mif.mul_end      = !mdl_busy && !end_low;
  assign mif.mul_dout_vld = mdl_vld | spur;
  assign mif.mul_dout     = spur ? spur_data : mdl_p;

  always @(posedge clk) begin
    mdl_vld <= 1'b0;
    if (mdl_busy) begin
      if (mdl_cnt <= 1) begin
        mdl_busy <= 1'b0;
        mdl_vld  <= !mute;
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end else if (mif.mul_in_vld && mif.mul_end) begin
      mdl_busy <= 1'b1;
      mdl_cnt  <= mul_lat;
      mdl_p    <= 16'(16'($signed(mif.mul_a)) * 16'($signed(mif.mul_b)));
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          idx;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          hold;
  } vec_t;

  vec_t vt[9];

  logic [7:0]  ha[4];
  logic [7:0]  hb[4];
  logic [15:0] hp[4];

  // Wait for resp_vld; also reports whether mul_dout_vld was seen the cycle before
  task automatic wait_resp(output bit got, output bit prev_dv);
    got     = 1'b0;
    prev_dv = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      #1;
      if (rif.resp_vld != '0) begin
        got = 1'b1;
        break;
      end
      prev_dv = mif.mul_dout_vld;
    end
  endtask

  task automatic do_txn(input int idx, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] p, input int hold, input string nm);
    bit got;
    bit prev_dv;
    @(negedge clk);
    end_low     = (hold > 0);
    rif.req_vld = NR'(1) << idx;
    rif.req_a   = 32'(a) << (idx * N);
    rif.req_b   = 32'(b) << (idx * N);
    #1;
    chk({nm, " rdy"}, 32'(rif.req_rdy), 32'(1) << idx);
    @(negedge clk);
    rif.req_vld = '0;
    #1;
    chk({nm, " busy"}, 32'(busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      chk({nm, " stall"}, 32'(mif.mul_in_vld), 32'd0);
      @(negedge clk);
    end
    end_low = 1'b0;
    #1;
    chk({nm, " start"}, 32'(mif.mul_in_vld), 32'd1);
    chk({nm, " mul_a"}, 32'(mif.mul_a), 32'(a));
    chk({nm, " mul_b"}, 32'(mif.mul_b), 32'(b));
    wait_resp(got, prev_dv);
    chk({nm, " resp seen"}, 32'(got), 32'd1);
    chk({nm, " resp latency"}, 32'(prev_dv), 32'd1);
    chk({nm, " resp_vld"}, 32'(rif.resp_vld), 32'(1) << idx);
    chk({nm, " resp_data"}, 32'(rif.resp_data), 32'(p));
    chk({nm, " resp_id"}, 32'(rif.resp_id), 32'(idx));
    @(negedge clk);
    #1;
    chk({nm, " pulse end"}, 32'(rif.resp_vld), 32'd0);
    chk({nm, " idle"}, 32'(busy), 32'd0);
  endtask

  // Hold the requesters in mask and check the grant order and routed results
  task automatic run_held(input logic [3:0] mask, input int n, input int ord[5], input string nm);
    bit got;
    bit prev_dv;
    @(negedge clk);
    rif.req_vld = mask;
    rif.req_a   = {ha[3], ha[2], ha[1], ha[0]};
    rif.req_b   = {hb[3], hb[2], hb[1], hb[0]};
    for (int g = 0; g < n; g++) begin
      got = 1'b0;
      for (int c = 0; c < 40; c++) begin
        #1;
        if (rif.req_rdy != '0) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk({nm, " grant seen"}, 32'(got), 32'd1);
      chk({nm, " grant"}, 32'(rif.req_rdy), 32'(1) << ord[g]);
      @(negedge clk);
      if (g == n - 1) rif.req_vld = '0;
      wait_resp(got, prev_dv);
      chk({nm, " resp seen"}, 32'(got), 32'd1);
      chk({nm, " resp_vld"}, 32'(rif.resp_vld), 32'(1) << ord[g]);
      chk({nm, " resp_id"}, 32'(rif.resp_id), 32'(ord[g]));
      chk({nm, " resp_data"}, 32'(rif.resp_data), 32'(hp[ord[g]]));
      chk({nm, " no accept in RESP"}, 32'(rif.req_rdy), 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rif.req_vld = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int cnt;
    bit got;
    int n;

    vt[0] = '{idx: 0, a: 8'h03, b: 8'hFB, p: 16'hFFF1, hold: 0};
    vt[1] = '{idx: 0, a: 8'h80, b: 8'h80, p: 16'h4000, hold: 0};
    vt[2] = '{idx: 0, a: 8'h80, b: 8'h7F, p: 16'hC080, hold: 0};
    vt[3] = '{idx: 1, a: 8'h64, b: 8'h03, p: 16'h012C, hold: 0};
    vt[4] = '{idx: 2, a: 8'hFE, b: 8'h32, p: 16'hFF9C, hold: 3};
    vt[5] = '{idx: 3, a: 8'h0C, b: 8'hF5, p: 16'hFF7C, hold: 0};
    vt[6] = '{idx: 1, a: 8'h7F, b: 8'h7F, p: 16'h3F01, hold: 0};
    vt[7] = '{idx: 2, a: 8'hFF, b: 8'hFF, p: 16'h0001, hold: 0};
    vt[8] = '{idx: 3, a: 8'h00, b: 8'h9C, p: 16'h0000, hold: 0};

    ha = '{8'h02, 8'hFD, 8'h07, 8'hF6};
    hb = '{8'h05, 8'h06, 8'hFC, 8'hF4};
    hp = '{16'h000A, 16'hFFEE, 16'hFFE4, 16'h0078};

    rst_n       = 1'b0;
    rif.req_vld = '0;
    rif.req_a   = '0;
    rif.req_b   = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("reset req_rdy", 32'(rif.req_rdy), 32'd0);
    chk("reset resp_vld", 32'(rif.resp_vld), 32'd0);
    chk("reset resp_data", 32'(rif.resp_data), 32'd0);
    chk("reset resp_id", 32'(rif.resp_id), 32'd0);
    chk("reset mul_in_vld", 32'(mif.mul_in_vld), 32'd0);
    chk("reset mul_a", 32'(mif.mul_a), 32'd0);
    chk("reset mul_b", 32'(mif.mul_b), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset tmo_err", 32'(tmo_err), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      do_txn(vt[i].idx, vt[i].a, vt[i].b, vt[i].p, vt[i].hold, $sformatf("vec%0d", i));

    // Stray multiplier pulse while idle must not produce a response
    @(negedge clk);
    spur_data = 16'h1234;
    spur      = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    #1;
    chk("stray dout resp_vld", 32'(rif.resp_vld), 32'd0);
    chk("stray dout busy", 32'(busy), 32'd0);

    do_reset();
    run_held(4'b1111, 5, '{0, 1, 2, 3, 0}, "rr all");

    do_reset();
    run_held(4'b0100, 1, '{2, 0, 0, 0, 0}, "rr req2");
    run_held(4'b1010, 2, '{3, 1, 0, 0, 0}, "rr past 2");

    // Reset while waiting on the multiplier discards the pending result
    mul_lat = 8;
    @(negedge clk);
    rif.req_vld = 4'b0001;
    rif.req_a   = 32'h0000_0005;
    rif.req_b   = 32'h0000_0006;
    @(negedge clk);
    rif.req_vld = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("wait busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst resp_vld", 32'(rif.resp_vld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (rif.resp_vld != '0) cnt++;
    end
    chk("rst no resp", 32'(cnt), 32'd0);
    mul_lat = 3;
    do_txn(1, 8'h09, 8'hF9, 16'hFFC1, 0, "after rst");

`ifdef QMULT_SCHED_TMO_EN
    // Silent multiplier: watchdog fires after TMO WAIT cycles
    mute = 1'b1;
    @(negedge clk);
    rif.req_vld = 4'b0001;
    rif.req_a   = 32'h0000_0003;
    rif.req_b   = 32'h0000_0003;
    @(negedge clk);
    rif.req_vld = '0;
    n   = 0;
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      n++;
      if (rif.resp_vld != '0) begin
        got = 1'b1;
        break;
      end
      chk("tmo err early", 32'(tmo_err), 32'd0);
    end
    chk("tmo resp seen", 32'(got), 32'd1);
    chk("tmo cycles", 32'(n), 32'(TMO + 1));
    chk("tmo err", 32'(tmo_err), 32'd1);
    chk("tmo resp_vld", 32'(rif.resp_vld), 32'd1);
    chk("tmo resp_data", 32'(rif.resp_data), 32'd0);
    chk("tmo resp_id", 32'(rif.resp_id), 32'd0);
    mute = 1'b0;
    repeat (4) @(negedge clk);
    do_txn(2, 8'h05, 8'h05, 16'h0019, 0, "post tmo");
    chk("tmo sticky", 32'(tmo_err), 32'd1);
    do_reset();
    #1;
    chk("tmo cleared", 32'(tmo_err), 32'd0);
`else
    chk("tmo tied", 32'(tmo_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
